audio_stream_ctrl: RTL and testbench

- Parametrised record/playback sequencer between the audio codec sample strobes and the DDR RAM wrapper port.
- Records multi-channel frames into RAM on ADC frame strobes.
- Plays them back on DAC request strobes, one-shot or looped.
- Tracks recorded length and reports overflow, dropped-frame and underrun conditions.

---
 rtl/audio_stream_ctrl_pkg.sv | 11 +
 rtl/audio_stream_ctrl_edge_sync.sv | 18 +
 rtl/audio_stream_ctrl.sv | 141 ++++++++++++++
 tb/tb_audio_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_ctrl_pkg.sv
// audio_stream_ctrl_pkg: sequencer states, mode encodings and LED bit positions
package audio_stream_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE, REC_WAIT, REC_WR, REC_FULL, PLAY_FETCH, PLAY_READY, PLAY_END, ABORT
  } state_t;
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PLAY = 2'b01;
  localparam logic [1:0] MODE_REC = 2'b10;
  localparam int LED_PLAY = 0;
  localparam int LED_REC = 1;
endpackage

// File: rtl/audio_stream_ctrl_edge_sync.sv
// audio_stream_ctrl_edge_sync: two-flop synchroniser with a registered rising-edge pulse
module audio_stream_ctrl_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic p
);
  logic [2:0] s;
  // shift the strobe through two sync flops, then flag a 0->1 step as a one-cycle pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s <= '0;
      p <= 1'b0;
    end else begin
      s <= {s[1:0], d};
      p <= s[1] & ~s[2];
    end
endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: record/playback sequencer between codec frame strobes and the RAM wrapper
module audio_stream_ctrl
  import audio_stream_ctrl_pkg::*;
#(
  parameter int SW = 16,
  parameter int CH = 2,
  parameter int AW = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             loop_en,
  input  logic             s_end,
  input  logic             s_req,
  input  logic [CH*SW-1:0] audio_in,
  output logic [CH*SW-1:0] audio_out,
  input  logic [AW-1:0]    max_addr,
  input  logic             ram_rdy,
  output logic [AW-1:0]    ram_addr,
  output logic [SW-1:0]    ram_wdata,
  output logic             ram_we,
  output logic             ram_rd_req,
  input  logic             ram_rd_pres,
  output logic             ram_rd_ack,
  input  logic [SW-1:0]    ram_rdata,
  output logic [AW-1:0]    rec_len,
  output logic [1:0]       led,
  output logic             done,
  output logic             ovf,
  output logic             drop,
  output logic             urun
);
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LAST = CW'(CH - 1);
  state_t state;
  logic [1:0] ent_mode;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] c;
  logic [CH-1:0][SW-1:0] fbuf;
  logic ev_end, ev_req, word_last, fits;
  audio_stream_ctrl_edge_sync u_end (.clk(clk), .reset(reset), .d(s_end), .p(ev_end));
  audio_stream_ctrl_edge_sync u_req (.clk(clk), .reset(reset), .d(s_req), .p(ev_req));
  assign word_last = c == LAST;
  assign fits = {1'b0, wr_ptr} + (AW + 1)'(CH - 1) <= {1'b0, max_addr};
  assign ram_we = state == REC_WR && ram_rdy;
  assign ram_addr = ram_rd_req ? rd_ptr : state == REC_WR ? wr_ptr : '0;
  assign ram_wdata = state == REC_WR ? fbuf[c] : '0;
  assign led[LED_PLAY] = state inside {PLAY_FETCH, PLAY_READY, PLAY_END};
  assign led[LED_REC] = state inside {REC_WAIT, REC_WR, REC_FULL};
  // sequencer: record frames word by word, fetch and present frames on request, unwind on mode change
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ent_mode <= MODE_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      c <= '0;
      fbuf <= '0;
      rec_len <= '0;
      audio_out <= '0;
      ram_rd_req <= 1'b0;
      ram_rd_ack <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      drop <= 1'b0;
      urun <= 1'b0;
    end else begin
      ram_rd_ack <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          ent_mode <= mode;
          c <= '0;
          if (mode == MODE_REC) begin
            state <= REC_WAIT;
            wr_ptr <= '0;
            rec_len <= '0;
            ovf <= 1'b0;
            drop <= 1'b0;
          end else if (mode == MODE_PLAY) begin
            rd_ptr <= '0;
            urun <= 1'b0;
            state <= rec_len == '0 ? PLAY_END : PLAY_FETCH;
            done <= rec_len == '0;
          end
        end
        REC_WAIT: if (ev_end) begin
          fbuf <= audio_in;
          c <= '0;
          state <= fits ? REC_WR : REC_FULL;
          ovf <= ovf | ~fits;
        end
        REC_WR: begin
          drop <= drop | ev_end;
          if (ram_rdy) begin
            wr_ptr <= wr_ptr + 1'b1;
            c <= c + 1'b1;
            if (word_last) begin
              rec_len <= rec_len + AW'(CH);
              state <= REC_WAIT;
            end
          end
        end
        REC_FULL: ;
        PLAY_FETCH: begin
          urun <= urun | ev_req;
          if (ram_rd_req && ram_rd_pres) begin
            fbuf[c] <= ram_rdata;
            ram_rd_req <= 1'b0;
            ram_rd_ack <= 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
            c <= c + 1'b1;
            if (word_last) state <= PLAY_READY;
          end else if (!ram_rd_req && !ram_rd_ack) ram_rd_req <= 1'b1;
        end
        PLAY_READY: if (ev_req) begin
          audio_out <= fbuf;
          c <= '0;
          if (rd_ptr < rec_len) state <= PLAY_FETCH;
          else if (loop_en) begin
            rd_ptr <= '0;
            state <= PLAY_FETCH;
          end else begin
            done <= 1'b1;
            state <= PLAY_END;
          end
        end
        PLAY_END: if (ev_req) audio_out <= '0;
        ABORT: if (ram_rd_pres) begin
          ram_rd_req <= 1'b0;
          ram_rd_ack <= 1'b1;
          state <= IDLE;
        end
      endcase
      if (state != IDLE && state != ABORT && mode != ent_mode) begin
        state <= ram_rd_req && !ram_rd_pres ? ABORT : IDLE;
        ram_rd_req <= ram_rd_req && !ram_rd_pres;
        ram_rd_ack <= ram_rd_req && ram_rd_pres;
      end
    end
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb_audio_stream_ctrl: directed record/playback scenarios checked against a frame-level model
module tb_audio_stream_ctrl;
  localparam int SW = 16;
  localparam int CH = 2;
  localparam int AW = 26;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] mode;
  logic loop_en, s_end, s_req, ram_rdy;
  logic [CH*SW-1:0] audio_in, audio_out;
  logic [AW-1:0] max_addr, ram_addr, rec_len;
  logic [SW-1:0] ram_wdata;
  logic [SW-1:0] ram_rdata = '0;
  logic ram_we, ram_rd_req, ram_rd_ack, done, ovf, drop, urun;
  logic ram_rd_pres = 1'b0;
  logic [1:0] led;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int rcnt = 0;
  bit hold_pres = 1'b0;
  logic [SW-1:0] mem [0:63];
  logic [CH*SW-1:0] m_frames[$];
  logic [AW+SW-1:0] exp_wr[$];
  int m_idx, m_words;
  bit m_ended, m_full;
  bit m_urun = 1'b0;
  logic [CH*SW-1:0] exp_out = '0;
  logic exp_done = 1'b0;

  audio_stream_ctrl #(.SW(SW), .CH(CH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .loop_en(loop_en), .s_end(s_end), .s_req(s_req),
    .audio_in(audio_in), .audio_out(audio_out), .max_addr(max_addr), .ram_rdy(ram_rdy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rd_req(ram_rd_req),
    .ram_rd_pres(ram_rd_pres), .ram_rd_ack(ram_rd_ack), .ram_rdata(ram_rdata),
    .rec_len(rec_len), .led(led), .done(done), .ovf(ovf), .drop(drop), .urun(urun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RAM wrapper read side: data presented two cycles after a request, one-cycle present pulse
  always @(posedge clk)
    if (ram_rd_pres) begin
      ram_rd_pres <= 1'b0;
      rcnt <= 0;
    end else if (ram_rd_req && !hold_pres) begin
      if (rcnt == 1) begin
        ram_rd_pres <= 1'b1;
        ram_rdata <= mem[ram_addr[5:0]];
      end
      rcnt <= rcnt + 1;
    end

  // per-cycle compare of playback output, done, underrun and every RAM write
  always @(negedge clk)
    if (reset) begin
      chk("audio_out", audio_out, exp_out);
      chk("done", 32'(done), 32'(exp_done));
      chk("urun", 32'(urun), 32'(m_urun));
      if (done) done_cnt++;
      if (ram_we) begin
        if (exp_wr.size() == 0) chk("spurious_we", 32'(ram_we), 32'd0);
        else begin
          logic [AW+SW-1:0] w;
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(w[AW+SW-1:SW]));
          chk("wr_data", 32'(ram_wdata), 32'(w[SW-1:0]));
        end
        mem[ram_addr[5:0]] = ram_wdata;
      end
    end

  task automatic start_rec();
    m_words = 0;
    m_full = 1'b0;
    m_frames.delete();
    mode = 2'b10;
    tick(2);
  endtask

  task automatic stop();
    mode = 2'b00;
    tick(3);
  endtask

  task automatic rec_frame(input logic [CH*SW-1:0] f);
    audio_in = f;
    if (!m_full) begin
      if (m_words + CH - 1 > int'(max_addr)) m_full = 1'b1;
      else begin
        for (int i = 0; i < CH; i++) exp_wr.push_back({AW'(m_words + i), f[i*SW +: SW]});
        m_frames.push_back(f);
        m_words += CH;
      end
    end
    s_end = 1'b1;
    tick(4);
    s_end = 1'b0;
    tick(8);
  endtask

  task automatic start_play(input bit l);
    loop_en = l;
    m_idx = 0;
    m_ended = 1'b0;
    mode = 2'b01;
    tick(14);
  endtask

  task automatic pulse_req(input bit ready);
    s_req = 1'b1;
    repeat (4) @(posedge clk);
    if (m_ended) exp_out = '0;
    else if (!ready) m_urun = 1'b1;
    else begin
      exp_out = m_frames[m_idx];
      m_idx++;
      if (m_idx == m_frames.size()) begin
        if (loop_en) m_idx = 0;
        else begin
          m_ended = 1'b1;
          exp_done = 1'b1;
        end
      end
    end
    @(posedge clk);
    exp_done = 1'b0;
    #1;
    s_req = 1'b0;
    tick(14);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mode = 2'b00;
    loop_en = 1'b0;
    s_end = 1'b0;
    s_req = 1'b0;
    audio_in = '0;
    max_addr = AW'(63);
    ram_rdy = 1'b1;
    tick(3);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_rec_len", 32'(rec_len), 32'd0);
    chk("rst_audio_out", audio_out, 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rd_req", 32'(ram_rd_req), 32'd0);
    chk("rst_flags", 32'({done, ovf, drop, urun, ram_rd_ack}), 32'd0);
    reset = 1'b1;
    tick(2);

    start_rec();
    for (int n = 0; n < 4; n++) rec_frame(32'hBBBB_AAAA + 32'(n));
    chk("rec_len_8", 32'(rec_len), 32'd8);
    chk("rec_len_model", 32'(rec_len), 32'(m_words));
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
    chk("mem6", 32'(mem[6]), 32'h0000_AAAD);
    chk("mem7", 32'(mem[7]), 32'h0000_BBBB);
    chk("drop_clear", 32'(drop), 32'd0);
    stop();

    start_play(1'b0);
    for (int n = 0; n < 5; n++) begin
      pulse_req(1'b1);
      if (n == 0) chk("first_frame", audio_out, 32'hBBBB_AAAA);
      if (n == 3) chk("last_frame", audio_out, 32'hBBBB_AAAD);
    end
    chk("play_end_out", audio_out, 32'd0);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("play_urun", 32'(urun), 32'd0);
    chk("play_end_led", 32'(led), 32'd1);
    stop();

    max_addr = AW'(5);
    start_rec();
    for (int n = 0; n < 4; n++) rec_frame(32'h2222_1111 + 32'(n));
    chk("ovf_rec_len", 32'(rec_len), 32'd6);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_model", 32'(ovf), 32'(m_full));
    chk("full_led", 32'(led), 32'd2);
    chk("ovf_writes_left", 32'(exp_wr.size()), 32'd0);
    stop();
    max_addr = AW'(63);

    start_rec();
    for (int n = 0; n < 2; n++) rec_frame(32'h4444_3333 + 32'(n));
    chk("loop_rec_len", 32'(rec_len), 32'd4);
    stop();
    start_play(1'b1);
    for (int n = 0; n < 5; n++) begin
      pulse_req(1'b1);
      if (n == 1) chk("loop_f1", audio_out, 32'h4444_3334);
    end
    chk("loop_f0_again", audio_out, 32'h4444_3333);
    chk("loop_no_done", 32'(done_cnt), 32'd1);
    stop();

    hold_pres = 1'b1;
    start_play(1'b0);
    pulse_req(1'b0);
    chk("urun_set", 32'(urun), 32'd1);
    chk("urun_out_held", audio_out, 32'h4444_3333);
    chk("urun_req_held", 32'(ram_rd_req), 32'd1);
    mode = 2'b00;
    tick(3);
    chk("abort_req_held", 32'(ram_rd_req), 32'd1);
    chk("abort_led", 32'(led), 32'd0);
    hold_pres = 1'b0;
    begin
      int acks = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ram_rd_ack) acks++;
      end
      chk("abort_ack", 32'(acks), 32'd1);
    end
    chk("abort_req_drop", 32'(ram_rd_req), 32'd0);
    tick(1);

    ram_rdy = 1'b0;
    mode = 2'b10;
    tick(2);
    audio_in = 32'h6666_5555;
    s_end = 1'b1;
    tick(6);
    s_end = 1'b0;
    chk("stall_led", 32'(led), 32'd2);
    chk("stall_we", 32'(ram_we), 32'd0);
    ram_rdy = 1'b1;
    #1;
    chk("we_before_rst", 32'(ram_we), 32'd1);
    chk("wdata_before_rst", 32'(ram_wdata), 32'h0000_5555);
    reset = 1'b0;
    m_urun = 1'b0;
    exp_out = '0;
    #1;
    chk("async_rst_we", 32'(ram_we), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_addr", 32'(ram_addr), 32'd0);
    chk("async_rst_out", audio_out, 32'd0);
    chk("async_rst_flags", 32'({rec_len, urun, ovf}), 32'd0);
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
